uart_cmd_responder: RTL
=======================

Name: uart_cmd_responder

Overview:
- Command responder on the far side of the UART link: consumes received bytes from the UART receiver, decodes host command frames, drives register-file and ALU strobes, and returns response bytes through the UART transmitter.
- Sits between uart_top's RX/TX byte ports and the system register file / ALU.
- Single clock domain; both the uart_top RX output and the uart_top TX input must already be synchronised to clk.

Parameters:
- dataWidth, 8, width of UART byte, register data and ALU operands.
- addrWidth, 4, register-file address width; the address byte's low addrWidth bits are used.
- aluFunWidth, 4, ALU function code width; the function byte's low aluFunWidth bits are used.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- rx_p_data  input  dataWidth  received byte; valid only when rx_d_valid=1.
- rx_d_valid  input  1  one-cycle pulse per received byte.
- tx_p_data  output  dataWidth  byte to transmit.
- tx_d_valid  output  1  transmit request; held high until tx_busy seen high.
- tx_busy  input  1  transmitter busy.
- rf_addr  output  addrWidth  register-file address.
- rf_wr_en  output  1  one-cycle write strobe.
- rf_wr_data  output  dataWidth  write data.
- rf_rd_en  output  1  one-cycle read strobe.
- rf_rd_data  input  dataWidth  read data.
- rf_rd_valid  input  1  read data valid pulse.
- alu_en  output  1  one-cycle ALU start strobe.
- alu_fun  output  aluFunWidth  ALU function code.
- alu_out  input  2*dataWidth  ALU result.
- alu_out_valid  input  1  result valid pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; internal byte buffer 0.
- All outputs registered. Strobes (rf_wr_en, rf_rd_en, alu_en) are exactly one cycle wide.
- Frames (first byte = command):
  - 0xAA addr data: register write.
  - 0xBB addr: register read, returns 1 byte.
  - 0xCC opA opB fun: ALU operation, returns 2 bytes, LSB first.
- IDLE: on rx_d_valid, 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→ALU_A. Any other byte is discarded; state stays IDLE.
- Write path:
  - WR_ADDR: on rx_d_valid, latch rf_addr and go to WR_DATA.
  - WR_DATA: on rx_d_valid, rf_wr_data<=byte and rf_wr_en=1 in the next cycle; then go to IDLE.
- Read path:
  - RD_ADDR: on rx_d_valid, latch rf_addr; rf_rd_en=1 in the next cycle; go to RD_WAIT.
  - RD_WAIT: on rf_rd_valid, load the response buffer with rf_rd_data and go to TX_REQ with byte count 1.
- ALU path:
  - ALU_A: on rx_d_valid, write the byte to rf_addr=0 (rf_wr_en pulse); go to ALU_B.
  - ALU_B: on rx_d_valid, write the byte to rf_addr=1; go to ALU_FUN.
  - ALU_FUN: on rx_d_valid, latch alu_fun; alu_en=1 in the next cycle; go to ALU_WAIT.
  - ALU_WAIT: on alu_out_valid, buffer alu_out; go to TX_REQ with byte count 2.
- Transmit path:
  - TX_REQ: wait for tx_busy=0; drive tx_p_data=current byte, tx_d_valid=1; go to TX_HOLD.
  - TX_HOLD: keep tx_d_valid=1 and tx_p_data stable until tx_busy=1; then drop tx_d_valid and go to TX_DONE.
  - TX_DONE: wait for tx_busy=0. If bytes remain, advance to the MSB and go to TX_REQ; otherwise go to IDLE.
- rx_d_valid arriving in RD_WAIT, ALU_WAIT, TX_REQ, TX_HOLD or TX_DONE is dropped; no queueing.
- rf_rd_valid or alu_out_valid arriving outside its wait state is ignored.
- rx_d_valid in the same cycle as a transition into IDLE: the byte is evaluated by IDLE in the following cycle only if still valid, i.e. it is lost. The host must space frames.
- Reset asserted mid-frame or mid-transmit: immediate return to IDLE, tx_d_valid=0, partial frame discarded.
- Address/function bytes are truncated to their low bits; no range error.

Optional Feature:
- Macro: UART_CMD_WRITE_ACK_EN.
- Defined: after a 0xAA write strobe, the block enters TX_REQ with byte count 1 and echoes the written data byte as an acknowledge.
- Undefined: writes produce no TX traffic and WR_DATA returns directly to IDLE.

Test Plan:
- Write: rx bytes 0xAA,0x05,0x3C → one rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C; tx_d_valid stays 0. With UART_CMD_WRITE_ACK_EN, one tx byte 0x3C.
- Read: rx 0xBB,0x07; model returns rf_rd_data=0x5A with rf_rd_valid → rf_rd_en pulse at addr 7, then exactly one tx byte 0x5A.
- ALU: rx 0xCC,0x12,0x34,0x02; alu_out=0x0468 → RF writes 0x12@0 and 0x34@1, alu_fun=2, alu_en pulse, then tx 0x68 followed by 0x04.
- TX backpressure: hold tx_busy=1 for 50 cycles before the first byte → tx_d_valid held with stable data, no byte lost or repeated.
- Robustness: bytes 0x00 then 0xFF in IDLE are ignored; a following 0xBB read still works. Assert rst during TX_HOLD → outputs return to 0 and state to IDLE; the next frame works.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// UART command responder: decodes write/read/ALU frames and returns response bytes.
// Optional write acknowledge echo enabled with UART_CMD_WRITE_ACK_EN.
module uart_cmd_responder #(
    parameter int dataWidth   = 8,
    parameter int addrWidth   = 4,
    parameter int aluFunWidth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [dataWidth-1:0]   rx_p_data,
    input  logic                   rx_d_valid,
    output logic [dataWidth-1:0]   tx_p_data,
    output logic                   tx_d_valid,
    input  logic                   tx_busy,
    output logic [addrWidth-1:0]   rf_addr,
    output logic                   rf_wr_en,
    output logic [dataWidth-1:0]   rf_wr_data,
    output logic                   rf_rd_en,
    input  logic [dataWidth-1:0]   rf_rd_data,
    input  logic                   rf_rd_valid,
    output logic                   alu_en,
    output logic [aluFunWidth-1:0] alu_fun,
    input  logic [2*dataWidth-1:0] alu_out,
    input  logic                   alu_out_valid
);

    localparam logic [dataWidth-1:0] CmdWr  = dataWidth'(8'hAA);
    localparam logic [dataWidth-1:0] CmdRd  = dataWidth'(8'hBB);
    localparam logic [dataWidth-1:0] CmdAlu = dataWidth'(8'hCC);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        ALU_A, ALU_B, ALU_FUN, ALU_WAIT,
        TX_REQ, TX_HOLD, TX_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [addrWidth-1:0]     addr_q, addr_d;
    logic [dataWidth-1:0]     wr_data_q, wr_data_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic                     alu_en_q, alu_en_d;
    logic [aluFunWidth-1:0]   fun_q, fun_d;
    logic [dataWidth-1:0]     txd_q, txd_d;
    logic                     txv_q, txv_d;
    logic [2*dataWidth-1:0]   buf_q, buf_d;
    logic [1:0]               cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            fun_q     <= '0;
            txd_q     <= '0;
            txv_q     <= 1'b0;
            buf_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            fun_q     <= fun_d;
            txd_q     <= txd_d;
            txv_q     <= txv_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        fun_d     = fun_q;
        txd_d     = txd_q;
        txv_d     = txv_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rx_d_valid) begin
                    if (rx_p_data == CmdWr)       state_d = WR_ADDR;
                    else if (rx_p_data == CmdRd)  state_d = RD_ADDR;
                    else if (rx_p_data == CmdAlu) state_d = ALU_A;
                end
            end
            WR_ADDR: begin
                if (rx_d_valid) begin
                    addr_d  = rx_p_data[addrWidth-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_d_valid) begin
                    wr_data_d = rx_p_data;
                    wr_en_d   = 1'b1;
`ifdef UART_CMD_WRITE_ACK_EN
                    buf_d     = {{dataWidth{1'b0}}, rx_p_data};
                    cnt_d     = 2'd1;
                    state_d   = TX_REQ;
`else
                    state_d   = IDLE;
`endif
                end
            end
            RD_ADDR: begin
                if (rx_d_valid) begin
                    addr_d  = rx_p_data[addrWidth-1:0];
                    rd_en_d = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rf_rd_valid) begin
                    buf_d   = {{dataWidth{1'b0}}, rf_rd_data};
                    cnt_d   = 2'd1;
                    state_d = TX_REQ;
                end
            end
            // Operands are staged in RF slots 0 and 1 where the ALU reads them
            ALU_A: begin
                if (rx_d_valid) begin
                    addr_d    = '0;
                    wr_data_d = rx_p_data;
                    wr_en_d   = 1'b1;
                    state_d   = ALU_B;
                end
            end
            ALU_B: begin
                if (rx_d_valid) begin
                    addr_d    = addrWidth'(1);
                    wr_data_d = rx_p_data;
                    wr_en_d   = 1'b1;
                    state_d   = ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (rx_d_valid) begin
                    fun_d    = rx_p_data[aluFunWidth-1:0];
                    alu_en_d = 1'b1;
                    state_d  = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (alu_out_valid) begin
                    buf_d   = alu_out;
                    cnt_d   = 2'd2;
                    state_d = TX_REQ;
                end
            end
            TX_REQ: begin
                if (!tx_busy) begin
                    txd_d   = buf_q[dataWidth-1:0];
                    txv_d   = 1'b1;
                    state_d = TX_HOLD;
                end
            end
            TX_HOLD: begin
                if (tx_busy) begin
                    txv_d   = 1'b0;
                    state_d = TX_DONE;
                end
            end
            TX_DONE: begin
                if (!tx_busy) begin
                    if (cnt_q > 2'd1) begin
                        cnt_d   = cnt_q - 2'd1;
                        buf_d   = buf_q >> dataWidth;
                        state_d = TX_REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_p_data  = txd_q;
    assign tx_d_valid = txv_q;
    assign rf_addr    = addr_q;
    assign rf_wr_en   = wr_en_q;
    assign rf_wr_data = wr_data_q;
    assign rf_rd_en   = rd_en_q;
    assign alu_en     = alu_en_q;
    assign alu_fun    = fun_q;

endmodule
